uart_rx_buffer: RTL and testbench

- 8N1 UART receiver with an integrated receive FIFO. It is the receive-side counterpart to the SoC's UART transmit path.
- It samples the asynchronous `rx` pin, reassembles bytes LSB-first, and queues them in a first-word-fall-through FIFO.
- It sits between the board `rx` pin and the SoC bus/peripheral logic, which drains bytes with a read strobe.
- It reports framing errors and overruns through sticky flags.

---
 rtl/uart_rx_buffer.sv | 155 +++++++++++++++
 tb/tb_uart_rx_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffer.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Framing errors and overruns are reported through sticky flags.
module uart_rx_buffer #(
  parameter int CLOCK_FREQ  = 50000000,
  parameter int BIT_RATE    = 115200,
  parameter int BUFFER_SIZE = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rx,
  input  logic                         rd_en,
  output logic [7:0]                   rd_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(BUFFER_SIZE):0] count,
  output logic                         frame_err,
  output logic                         overrun,
  input  logic                         clr_err
);

  localparam int CPB = CLOCK_FREQ / BIT_RATE;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(BUFFER_SIZE);

  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  logic          rx_meta;
  logic          rxs;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic [7:0]    mem [BUFFER_SIZE];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic stop_tick;
  logic push_req;
  logic frame_set;
  logic ovr_set;
  logic do_push;
  logic do_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rxs) state <= START;
        end
        START: begin
          if (cnt == HALF) begin
            cnt   <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt            <= '0;
            shift[bit_idx] <= rxs;
            bit_idx        <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= rxs ? IDLE : WAIT_HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          cnt <= '0;
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stop_tick = (state == STOP) && (cnt == LAST);
  assign push_req  = stop_tick && rxs;
  assign frame_set = stop_tick && !rxs;

  // A full FIFO still accepts the byte if a pop frees a slot this cycle.
  assign do_pop  = rd_en && !empty;
  assign do_push = push_req && (!full || do_pop);
  assign ovr_set = push_req && full && !rd_en;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_set)    frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (ovr_set)      overrun   <= 1'b1;
      else if (clr_err) overrun   <= 1'b0;
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == (AW + 1)'(BUFFER_SIZE));
  assign rd_data = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer with CPB=16 and a 4-entry FIFO.
// Frames are driven on the falling clock edge, one bit per 16 cycles.
module tb_uart_rx_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       frame_err;
  logic       overrun;

  int n_chk  = 0;
  int n_fail = 0;
  int fall_c = -1;
  int max_cnt = 0;

  typedef struct {
    logic [7:0] data;
    int         exp_count;
    logic       exp_full;
    logic       exp_ovr;
  } vec_t;

  vec_t fill_tab[5];

  uart_rx_buffer #(
    .CLOCK_FREQ (16),
    .BIT_RATE   (1),
    .BUFFER_SIZE(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .frame_err(frame_err),
    .overrun  (overrun),
    .clr_err  (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Stop bit is sampled on posedge 154 of the frame; pop_stop raises
  // rd_en for exactly that edge.
  task automatic send(input logic [7:0] b, input logic stop,
                      input bit pop_stop);
    int slot;
    fall_c = -1;
    for (int c = 0; c < 160; c++) begin
      @(negedge clk);
      if (fall_c < 0 && !empty) fall_c = c;
      slot = c / 16;
      if (slot == 0)      rx = 1'b0;
      else if (slot == 9) rx = stop;
      else                rx = b[slot-1];
      rd_en = pop_stop && (c == 154);
    end
  endtask

  task automatic pop(input string name, input logic [7:0] exp);
    @(negedge clk);
    check(name, {24'h0, rd_data}, {24'h0, exp});
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic clear_errs();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    fill_tab[0] = '{8'h01, 1, 1'b0, 1'b0};
    fill_tab[1] = '{8'h02, 2, 1'b0, 1'b0};
    fill_tab[2] = '{8'h03, 3, 1'b0, 1'b0};
    fill_tab[3] = '{8'h04, 4, 1'b1, 1'b0};
    fill_tab[4] = '{8'h05, 4, 1'b1, 1'b1};

    idle(3);
    check("rst_empty", {31'h0, empty}, 1);
    check("rst_full", {31'h0, full}, 0);
    check("rst_count", {29'h0, count}, 0);
    check("rst_rd_data", {24'h0, rd_data}, 0);
    check("rst_flags", {30'h0, frame_err, overrun}, 0);
    reset = 1'b1;
    idle(5);

    send(8'hA5, 1'b1, 1'b0);
    check("a5_fall_lo", {31'h0, fall_c >= 152}, 1);
    check("a5_fall_hi", {31'h0, fall_c <= 156}, 1);
    check("a5_count", {29'h0, count}, 1);
    pop("a5_data", 8'hA5);
    check("a5_empty", {31'h0, empty}, 1);
    check("a5_count0", {29'h0, count}, 0);

    for (int i = 0; i < 5; i++) begin
      send(fill_tab[i].data, 1'b1, 1'b0);
      idle(1);
      check($sformatf("fill%0d_count", i), {29'h0, count},
            fill_tab[i].exp_count);
      check($sformatf("fill%0d_full", i), {31'h0, full},
            {31'h0, fill_tab[i].exp_full});
      check($sformatf("fill%0d_ovr", i), {31'h0, overrun},
            {31'h0, fill_tab[i].exp_ovr});
    end
    for (int i = 0; i < 4; i++)
      pop($sformatf("fill_rd%0d", i), fill_tab[i].data);
    idle(1);
    check("fill_empty", {31'h0, empty}, 1);
    clear_errs();
    check("ovr_cleared", {31'h0, overrun}, 0);

    for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), 1'b1, 1'b0);
    idle(1);
    check("sim_full", {31'h0, full}, 1);
    send(8'h55, 1'b1, 1'b1);
    idle(1);
    check("sim_ovr", {31'h0, overrun}, 0);
    check("sim_count", {29'h0, count}, 4);
    pop("sim_rd0", 8'h12);
    pop("sim_rd1", 8'h13);
    pop("sim_rd2", 8'h14);
    pop("sim_rd3", 8'h55);
    idle(1);
    check("sim_empty", {31'h0, empty}, 1);

    send(8'h3C, 1'b0, 1'b0);
    idle(1);
    check("brk_ferr", {31'h0, frame_err}, 1);
    check("brk_count", {29'h0, count}, 0);
    idle(100);
    clear_errs();
    idle(40 * 16 - 100);
    check("brk_once", {31'h0, frame_err}, 0);
    check("brk_nobyte", {29'h0, count}, 0);
    rx = 1'b1;
    idle(20);
    send(8'h7E, 1'b1, 1'b0);
    idle(1);
    check("post_brk_count", {29'h0, count}, 1);
    check("post_brk_ferr", {31'h0, frame_err}, 0);
    pop("post_brk_data", 8'h7E);

    @(negedge clk);
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(30);
    check("glitch_count", {29'h0, count}, 0);
    check("glitch_flags", {30'h0, frame_err, overrun}, 0);

    send(8'h99, 1'b1, 1'b0);
    for (int c = 0; c < 72; c++) begin
      @(negedge clk);
      rx = (c < 16) ? 1'b0 : 1'b1;
    end
    reset = 1'b0;
    idle(3);
    check("abort_empty", {31'h0, empty}, 1);
    check("abort_count", {29'h0, count}, 0);
    check("abort_rd_data", {24'h0, rd_data}, 0);
    check("abort_full", {31'h0, full}, 0);
    reset = 1'b1;
    idle(20);
    check("abort_nopart", {29'h0, count}, 0);
    send(8'h42, 1'b1, 1'b0);
    idle(1);
    check("abort_42_count", {29'h0, count}, 1);
    pop("abort_42_data", 8'h42);

    for (int i = 0; i < 10; i++) begin
      send(8'(i), 1'b1, 1'b0);
      idle(1);
      if (int'(count) > max_cnt) max_cnt = int'(count);
      pop($sformatf("wrap_rd%0d", i), 8'(i));
    end
    idle(1);
    check("wrap_max_count", max_cnt, 1);
    check("wrap_empty", {31'h0, empty}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
